pipe_control: RTL and testbench

Pipelined control unit for the 5-stage LEGv8 core. Decodes the 11-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and requests a one-cycle stall. Squashes wrong-path instructions when a branch resolves taken in MEM. It replaces the single-cycle combinational decoder and sits beside the datapath pipeline registers.

---
 rtl/pipe_control.sv | 219 +++++++++++++++++++++
 tb/tb_pipe_control.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// pipe_control: pipelined control unit for the 5-stage LEGv8 core.
// Decodes the ID opcode, carries the control bundle through the ID/EX,
// EX/MEM and MEM/WB control registers, raises the load-use stall and
// squashes wrong-path instructions when a branch resolves taken in MEM.
module pipe_control #(
  parameter int RAW       = 5,
  parameter int ZERO_REG  = 31,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [10:0]    opcode,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rn,
  input  logic [RAW-1:0] id_rm,
  input  logic [RAW-1:0] id_rd,
  input  logic           branch_taken,
  output logic           id_reg2loc,
  output logic [2:0]     id_signop,
  output logic           ex_alusrc,
  output logic [3:0]     ex_aluop,
  output logic           mem_memread,
  output logic           mem_memwrite,
  output logic           mem_branch,
  output logic           mem_uncond_branch,
  output logic           wb_regwrite,
  output logic           wb_mem2reg,
  output logic [RAW-1:0] ex_rd,
  output logic [RAW-1:0] mem_rd,
  output logic [RAW-1:0] wb_rd,
  output logic           stall,
  output logic           flush,
  output logic           illegal_op
);

  localparam logic [RAW-1:0] ZERO_IDX = RAW'(ZERO_REG);

  // Each stage register keeps only the fields still consumed downstream.
  typedef struct packed {
    logic           alusrc;
    logic [3:0]     aluop;
    logic           memread;
    logic           memwrite;
    logic           branch;
    logic           uncond;
    logic           regwrite;
    logic           mem2reg;
    logic [RAW-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic           memread;
    logic           memwrite;
    logic           branch;
    logic           uncond;
    logic           regwrite;
    logic           mem2reg;
    logic [RAW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic           regwrite;
    logic           mem2reg;
    logic [RAW-1:0] rd;
  } wb_ctrl_t;

  // Decode results. ctl packs reg2loc/alusrc/mem2reg/regwrite/memread/
  // memwrite/branch/uncond, MSB first.
  logic [7:0]     ctl;
  logic [3:0]     dec_aluop;
  logic [2:0]     dec_signop;
  logic           dec_hit;
  logic           use_rn;
  logic           use_src2;
  logic           src2_is_rd;
  logic [RAW-1:0] src2;
  ex_ctrl_t       dec;
  logic           load_use;

  ex_ctrl_t  id_ex_d,  id_ex_q;
  mem_ctrl_t ex_mem_d, ex_mem_q;
  wb_ctrl_t  mem_wb_d, mem_wb_q;
  logic      illegal_d, illegal_q;

  // ID decode: first matching row wins; invalid or unmatched gives a bubble.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    ctl        = '0;
    dec_aluop  = '0;
    dec_signop = '0;
    dec_hit    = 1'b0;
    use_rn     = 1'b0;
    use_src2   = 1'b0;
    src2_is_rd = 1'b0;
    if (id_valid) begin
      dec_hit = 1'b1;
      casez (opcode)
        11'b?0001010???: begin ctl = 8'b0001_0000; dec_aluop = 4'b0000; use_rn = 1'b1; use_src2 = 1'b1; end
        11'b?0101010???: begin ctl = 8'b0001_0000; dec_aluop = 4'b0001; use_rn = 1'b1; use_src2 = 1'b1; end
        11'b?0?01011???: begin ctl = 8'b0001_0000; dec_aluop = 4'b0010; use_rn = 1'b1; use_src2 = 1'b1; end
        11'b?1?01011???: begin ctl = 8'b0001_0000; dec_aluop = 4'b0110; use_rn = 1'b1; use_src2 = 1'b1; end
        11'b?0?10001???: begin ctl = 8'b0101_0000; dec_aluop = 4'b0010; use_rn = 1'b1; end
        11'b?1?10001???: begin ctl = 8'b0101_0000; dec_aluop = 4'b0110; use_rn = 1'b1; end
        11'b110100101??: begin
          ctl        = 8'b1101_0000;
          dec_aluop  = {2'b11, opcode[1:0]};
          dec_signop = 3'b100;
        end
        11'b?00101?????: begin ctl = 8'b0100_0001; dec_aluop = 4'b0111; dec_signop = 3'b010; end
        11'b?011010????: begin
          ctl        = 8'b1000_0010;
          dec_aluop  = 4'b0111;
          dec_signop = 3'b011;
          use_src2   = 1'b1;
          src2_is_rd = 1'b1;
        end
        11'b??111000010: begin
          ctl        = 8'b0111_1000;
          dec_aluop  = 4'b0010;
          dec_signop = 3'b001;
          use_rn     = 1'b1;
        end
        11'b??111000000: begin
          ctl        = 8'b1100_0100;
          dec_aluop  = 4'b0010;
          dec_signop = 3'b001;
          use_rn     = 1'b1;
          use_src2   = 1'b1;
          src2_is_rd = 1'b1;
        end
        default: dec_hit = 1'b0;
      endcase
    end
  end

  assign id_reg2loc = ctl[7];
  assign id_signop  = dec_signop;
  assign src2       = src2_is_rd ? id_rd : id_rm;

  assign dec = '{alusrc:   ctl[6],
                 aluop:    dec_aluop,
                 memread:  ctl[3],
                 memwrite: ctl[2],
                 branch:   ctl[1],
                 uncond:   ctl[0],
                 regwrite: ctl[4],
                 mem2reg:  ctl[5],
                 rd:       dec_hit ? id_rd : '0};

  // Load-use interlock: a load in EX whose destination feeds a source the
  // ID instruction actually reads. XZR never creates a dependency.
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN && id_ex_q.memread && (id_ex_q.rd != ZERO_IDX)) begin
      load_use = (use_rn && (id_rn == id_ex_q.rd)) ||
                 (use_src2 && (src2 == id_ex_q.rd));
    end
  end

  // A taken branch squashes the ID instruction, so it overrides the stall.
  assign stall = load_use & ~branch_taken;
  assign flush = branch_taken;

  // Next-state for the control registers.
  always_comb begin
    id_ex_d = (stall || branch_taken) ? '0 : dec;

    ex_mem_d = '0;
    if (!branch_taken) begin
      ex_mem_d = '{memread:  id_ex_q.memread,
                   memwrite: id_ex_q.memwrite,
                   branch:   id_ex_q.branch,
                   uncond:   id_ex_q.uncond,
                   regwrite: id_ex_q.regwrite,
                   mem2reg:  id_ex_q.mem2reg,
                   rd:       id_ex_q.rd};
    end

    // The resolving branch itself still retires; it never writes a register.
    mem_wb_d = '{regwrite: ex_mem_q.regwrite,
                 mem2reg:  ex_mem_q.mem2reg,
                 rd:       ex_mem_q.rd};

    // A stalled decode is repeated next cycle, so it is not judged yet.
    illegal_d = illegal_q | (id_valid & ~dec_hit & ~stall);
  end

  // Control registers with synchronous reset to bubble.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      id_ex_q   <= '0;
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      id_ex_q   <= id_ex_d;
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_alusrc         = id_ex_q.alusrc;
  assign ex_aluop          = id_ex_q.aluop;
  assign ex_rd             = id_ex_q.rd;
  assign mem_memread       = ex_mem_q.memread;
  assign mem_memwrite      = ex_mem_q.memwrite;
  assign mem_branch        = ex_mem_q.branch;
  assign mem_uncond_branch = ex_mem_q.uncond;
  assign mem_rd            = ex_mem_q.rd;
  assign wb_regwrite       = mem_wb_q.regwrite;
  assign wb_mem2reg        = mem_wb_q.mem2reg;
  assign wb_rd             = mem_wb_q.rd;
  assign illegal_op        = illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: random and directed stimulus against an instruction-level
// model of the control pipeline. Two instances share the stimulus: u0 with
// the interlock enabled, u1 with it disabled.
module tb_pipe_control;

  logic        CLK;
  logic        reset;
  logic [10:0] opcode;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        branch_taken;

  logic       id_reg2loc_o [2];
  logic [2:0] id_signop_o  [2];
  logic       ex_alusrc_o  [2];
  logic [3:0] ex_aluop_o   [2];
  logic       mem_memread_o[2], mem_memwrite_o[2], mem_branch_o[2], mem_uncond_o[2];
  logic       wb_regwrite_o[2], wb_mem2reg_o[2];
  logic [4:0] ex_rd_o[2], mem_rd_o[2], wb_rd_o[2];
  logic       stall_o[2], flush_o[2], illegal_o[2];

  pipe_control #(.RAW(5), .ZERO_REG(31), .HAZARD_EN(1'b1)) u0 (
    .CLK(CLK), .reset(reset), .opcode(opcode), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .branch_taken(branch_taken),
    .id_reg2loc(id_reg2loc_o[0]), .id_signop(id_signop_o[0]),
    .ex_alusrc(ex_alusrc_o[0]), .ex_aluop(ex_aluop_o[0]),
    .mem_memread(mem_memread_o[0]), .mem_memwrite(mem_memwrite_o[0]),
    .mem_branch(mem_branch_o[0]), .mem_uncond_branch(mem_uncond_o[0]),
    .wb_regwrite(wb_regwrite_o[0]), .wb_mem2reg(wb_mem2reg_o[0]),
    .ex_rd(ex_rd_o[0]), .mem_rd(mem_rd_o[0]), .wb_rd(wb_rd_o[0]),
    .stall(stall_o[0]), .flush(flush_o[0]), .illegal_op(illegal_o[0]));

  pipe_control #(.RAW(5), .ZERO_REG(31), .HAZARD_EN(1'b0)) u1 (
    .CLK(CLK), .reset(reset), .opcode(opcode), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .branch_taken(branch_taken),
    .id_reg2loc(id_reg2loc_o[1]), .id_signop(id_signop_o[1]),
    .ex_alusrc(ex_alusrc_o[1]), .ex_aluop(ex_aluop_o[1]),
    .mem_memread(mem_memread_o[1]), .mem_memwrite(mem_memwrite_o[1]),
    .mem_branch(mem_branch_o[1]), .mem_uncond_branch(mem_uncond_o[1]),
    .wb_regwrite(wb_regwrite_o[1]), .wb_mem2reg(wb_mem2reg_o[1]),
    .ex_rd(ex_rd_o[1]), .mem_rd(mem_rd_o[1]), .wb_rd(wb_rd_o[1]),
    .stall(stall_o[1]), .flush(flush_o[1]), .illegal_op(illegal_o[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- instruction-level reference model ----------------
  typedef enum logic [3:0] {
    K_BUB, K_UNM, K_AND, K_ORR, K_ADD, K_SUB, K_ADDI, K_SUBI,
    K_MOVZ, K_B, K_CBZ, K_LDUR, K_STUR
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [1:0] hw;
    logic [4:0] rd;
  } rec_t;

  // Columns in table order: reg2loc alusrc mem2reg regwrite memread
  // memwrite branch uncond aluop signop.
  typedef struct packed {
    logic       reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch, uncond;
    logic [3:0] aluop;
    logic [2:0] signop;
  } ctrl_t;

  function automatic string pat_of(int k);
    case (k)
      0:  return "?0001010???";
      1:  return "?0101010???";
      2:  return "?0?01011???";
      3:  return "?1?01011???";
      4:  return "?0?10001???";
      5:  return "?1?10001???";
      6:  return "110100101??";
      7:  return "?00101?????";
      8:  return "?011010????";
      9:  return "??111000010";
      default: return "??111000000";
    endcase
  endfunction

  function automatic kind_e kind_of(int k);
    case (k)
      0: return K_AND;  1: return K_ORR;  2: return K_ADD;  3: return K_SUB;
      4: return K_ADDI; 5: return K_SUBI; 6: return K_MOVZ; 7: return K_B;
      8: return K_CBZ;  9: return K_LDUR; default: return K_STUR;
    endcase
  endfunction

  // Walk the pattern table top-down; character 0 is opcode bit 10.
  function automatic rec_t decode(logic v, logic [10:0] op, logic [4:0] rd);
    rec_t r;
    r = '0;
    if (!v) return r;
    for (int k = 0; k < 11; k++) begin
      string p;
      bit    ok;
      p  = pat_of(k);
      ok = 1'b1;
      for (int b = 0; b < 11; b++) begin
        byte c;
        c = p[b];
        if (c != "?" && ((c == "1") != (op[10-b] == 1'b1))) ok = 1'b0;
      end
      if (ok) begin
        r.kind = kind_of(k);
        r.hw   = op[1:0];
        r.rd   = rd;
        return r;
      end
    end
    r.kind = K_UNM;
    return r;
  endfunction

  function automatic ctrl_t ctrl_of(rec_t r);
    case (r.kind)
      K_AND:  return 15'b0_0_0_1_0_0_0_0_0000_000;
      K_ORR:  return 15'b0_0_0_1_0_0_0_0_0001_000;
      K_ADD:  return 15'b0_0_0_1_0_0_0_0_0010_000;
      K_SUB:  return 15'b0_0_0_1_0_0_0_0_0110_000;
      K_ADDI: return 15'b0_1_0_1_0_0_0_0_0010_000;
      K_SUBI: return 15'b0_1_0_1_0_0_0_0_0110_000;
      K_MOVZ: return {8'b1_1_0_1_0_0_0_0, 2'b11, r.hw, 3'b100};
      K_B:    return 15'b0_1_0_0_0_0_0_1_0111_010;
      K_CBZ:  return 15'b1_0_0_0_0_0_1_0_0111_011;
      K_LDUR: return 15'b0_1_1_1_1_0_0_0_0010_001;
      K_STUR: return 15'b1_1_0_0_0_1_0_0_0010_001;
      default: return '0;
    endcase
  endfunction

  // Does the ID instruction of kind k read register t?
  function automatic bit reads_reg(kind_e k, logic [4:0] t);
    bit rn_used, rm_used, rd_used;
    rn_used = k inside {K_AND, K_ORR, K_ADD, K_SUB, K_ADDI, K_SUBI, K_LDUR, K_STUR};
    rm_used = k inside {K_AND, K_ORR, K_ADD, K_SUB};
    rd_used = k inside {K_STUR, K_CBZ};
    return (rn_used && id_rn == t) || (rm_used && id_rm == t) || (rd_used && id_rd == t);
  endfunction

  rec_t m_ex[2], m_mem[2], m_wb[2];
  bit   m_ill[2];
  rec_t m_d;
  bit   m_st;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0; m_ill[i] = 1'b0;
    end
  end

  function automatic bit exp_stall(int i);
    ctrl_t c;
    rec_t  d;
    c = ctrl_of(m_ex[i]);
    d = decode(id_valid, opcode, id_rd);
    return (i == 0) && c.memread && (m_ex[i].rd != 5'd31) &&
           reads_reg(d.kind, m_ex[i].rd) && !branch_taken;
  endfunction

  // Advance the model on the same edge the DUT samples.
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0; m_ill[i] = 1'b0;
      end else begin
        m_d  = decode(id_valid, opcode, id_rd);
        m_st = exp_stall(i);
        if (m_d.kind == K_UNM && !m_st) m_ill[i] = 1'b1;
        m_wb[i]  = m_mem[i];
        m_mem[i] = branch_taken ? '0 : m_ex[i];
        m_ex[i]  = (branch_taken || m_st || m_d.kind == K_UNM) ? '0 : m_d;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_inst(int i);
    ctrl_t ce, cm, cw, ci;
    string u;
    u  = $sformatf("u%0d.", i);
    ce = ctrl_of(m_ex[i]);
    cm = ctrl_of(m_mem[i]);
    cw = ctrl_of(m_wb[i]);
    ci = ctrl_of(decode(id_valid, opcode, id_rd));
    check({u, "id_reg2loc"},   32'(id_reg2loc_o[i]),   32'(ci.reg2loc));
    check({u, "id_signop"},    32'(id_signop_o[i]),    32'(ci.signop));
    check({u, "ex_alusrc"},    32'(ex_alusrc_o[i]),    32'(ce.alusrc));
    check({u, "ex_aluop"},     32'(ex_aluop_o[i]),     32'(ce.aluop));
    check({u, "ex_rd"},        32'(ex_rd_o[i]),        32'(m_ex[i].rd));
    check({u, "mem_memread"},  32'(mem_memread_o[i]),  32'(cm.memread));
    check({u, "mem_memwrite"}, 32'(mem_memwrite_o[i]), 32'(cm.memwrite));
    check({u, "mem_branch"},   32'(mem_branch_o[i]),   32'(cm.branch));
    check({u, "mem_uncond"},   32'(mem_uncond_o[i]),   32'(cm.uncond));
    check({u, "mem_rd"},       32'(mem_rd_o[i]),       32'(m_mem[i].rd));
    check({u, "wb_regwrite"},  32'(wb_regwrite_o[i]),  32'(cw.regwrite));
    check({u, "wb_mem2reg"},   32'(wb_mem2reg_o[i]),   32'(cw.mem2reg));
    check({u, "wb_rd"},        32'(wb_rd_o[i]),        32'(m_wb[i].rd));
    check({u, "stall"},        32'(stall_o[i]),        32'(exp_stall(i)));
    check({u, "flush"},        32'(flush_o[i]),        32'(branch_taken));
    check({u, "illegal_op"},   32'(illegal_o[i]),      32'(m_ill[i]));
  endtask

  // Every-cycle comparison, well away from the rising edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) compare_inst(i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(bit v, logic [10:0] op, logic [4:0] rn, logic [4:0] rm,
                     logic [4:0] rd, bit bt);
    id_valid     = v;
    opcode       = op;
    id_rn        = rn;
    id_rm        = rm;
    id_rd        = rd;
    branch_taken = bt;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 3));
  endfunction

  // Random legal instruction: fill the don't-care bits of a table row.
  task automatic rand_inst();
    string       p;
    logic [10:0] op;
    p = pat_of(int'($urandom_range(0, 10)));
    for (int b = 0; b < 11; b++) begin
      byte c;
      c = p[b];
      op[10-b] = (c == "?") ? 1'($urandom_range(0, 1)) : (c == "1");
    end
    opcode   = op;
    id_valid = ($urandom_range(0, 7) != 0);
    id_rn    = pick_reg();
    id_rm    = pick_reg();
    id_rd    = pick_reg();
  endtask

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_B    = 11'h0A0;
  localparam logic [10:0] OP_CBZ  = 11'h5A0;
  localparam logic [10:0] OP_MOVZ = 11'h697;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_st, prev_bt, bt;

    reset = 1'b1;
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Random phase: IF/ID hold on stall, IF/ID clear after a flush, branch
    // outcome chosen when the u0 model has a branch in MEM.
    prev_st = 1'b0;
    prev_bt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      bt = 1'b0;
      if (m_mem[0].kind == K_B) bt = 1'b1;
      else if (m_mem[0].kind == K_CBZ) bt = 1'($urandom_range(0, 1));
      if (prev_bt) begin
        rand_inst();
        id_valid = 1'b0;
      end else if (!prev_st) begin
        rand_inst();
      end
      branch_taken = bt;
      #1;
      prev_st = exp_stall(0);
      prev_bt = bt;
    end

    // Reset state.
    reset = 1'b1;
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst.ex_aluop",    32'(ex_aluop_o[0]),    32'h0);
    check("rst.ex_rd",       32'(ex_rd_o[0]),       32'h0);
    check("rst.mem_memread", 32'(mem_memread_o[0]), 32'h0);
    check("rst.wb_regwrite", 32'(wb_regwrite_o[0]), 32'h0);
    check("rst.illegal_op",  32'(illegal_o[0]),     32'h0);
    check("rst.stall",       32'(stall_o[0]),       32'h0);
    check("rst.flush",       32'(flush_o[0]),       32'h0);

    // ADDREG latency through EX and WB.
    put(1'b1, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    #1;
    check("add.ex_aluop",  32'(ex_aluop_o[0]),  32'h2);
    check("add.ex_alusrc", 32'(ex_alusrc_o[0]), 32'h0);
    check("add.ex_rd",     32'(ex_rd_o[0]),     32'h5);
    tick();
    tick();
    #1;
    check("add.wb_regwrite", 32'(wb_regwrite_o[0]), 32'h1);
    check("add.wb_mem2reg",  32'(wb_mem2reg_o[0]),  32'h0);
    check("add.wb_rd",       32'(wb_rd_o[0]),       32'h5);

    // LDUR X2 then ADD using Rm=2: one stall, ADD reaches EX a cycle late.
    put(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    tick();
    put(1'b1, OP_ADD, 5'd3, 5'd2, 5'd4, 1'b0);
    #1;
    check("lu.stall",       32'(stall_o[0]), 32'h1);
    check("lu.stall_nohaz", 32'(stall_o[1]), 32'h0);
    tick();
    #1;
    check("lu.stall_once",    32'(stall_o[0]),       32'h0);
    check("lu.ex_bubble",     32'(ex_aluop_o[0]),    32'h0);
    check("lu.ex_rd_bubble",  32'(ex_rd_o[0]),       32'h0);
    check("lu.mem_memread",   32'(mem_memread_o[0]), 32'h1);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    #1;
    check("lu.add_ex_aluop", 32'(ex_aluop_o[0]), 32'h2);
    check("lu.add_ex_rd",    32'(ex_rd_o[0]),    32'h4);
    tick();
    tick();

    // Load to XZR never stalls.
    put(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd31, 1'b0);
    tick();
    put(1'b1, OP_ADD, 5'd3, 5'd31, 5'd4, 1'b0);
    #1;
    check("xzr.stall", 32'(stall_o[0]), 32'h0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();

    // LDUR X3 then STUR X3,[X4]: hazard via the Rd source.
    put(1'b1, OP_LDUR, 5'd5, 5'd0, 5'd3, 1'b0);
    tick();
    put(1'b1, OP_STUR, 5'd4, 5'd0, 5'd3, 1'b0);
    #1;
    check("stur.stall", 32'(stall_o[0]), 32'h1);
    tick();
    #1;
    check("stur.stall_once", 32'(stall_o[0]), 32'h0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();

    // LDUR X3 then B: B reads nothing.
    put(1'b1, OP_LDUR, 5'd5, 5'd0, 5'd3, 1'b0);
    tick();
    put(1'b1, OP_B, 5'd3, 5'd3, 5'd3, 1'b0);
    #1;
    check("b.stall", 32'(stall_o[0]), 32'h0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    tick();

    // CBZ taken in MEM, LDUR in EX, dependent ADD in ID.
    put(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd7, 1'b0);
    tick();
    put(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    tick();
    put(1'b1, OP_ADD, 5'd3, 5'd2, 5'd4, 1'b1);
    #1;
    check("br.flush",      32'(flush_o[0]),      32'h1);
    check("br.stall",      32'(stall_o[0]),      32'h0);
    check("br.mem_branch", 32'(mem_branch_o[0]), 32'h1);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    #1;
    check("br.mem_memread",  32'(mem_memread_o[0]), 32'h0);
    check("br.ex_bubble",    32'(ex_aluop_o[0]),    32'h0);
    check("br.wb_regwrite",  32'(wb_regwrite_o[0]), 32'h0);
    tick();
    #1;
    check("br.wb_regwrite2", 32'(wb_regwrite_o[0]), 32'h0);
    tick();
    tick();

    // MOVZ with hw=11.
    put(1'b1, OP_MOVZ, 5'd0, 5'd0, 5'd9, 1'b0);
    #1;
    check("movz.id_signop",  32'(id_signop_o[0]),  32'h4);
    check("movz.id_reg2loc", 32'(id_reg2loc_o[0]), 32'h1);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    #1;
    check("movz.ex_aluop",  32'(ex_aluop_o[0]),  32'hF);
    check("movz.ex_alusrc", 32'(ex_alusrc_o[0]), 32'h1);
    check("movz.ex_rd",     32'(ex_rd_o[0]),     32'h9);
    tick();
    tick();

    // Unmatched opcode: bubble, then sticky illegal_op.
    put(1'b1, 11'h000, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    check("ill.before", 32'(illegal_o[0]), 32'h0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    #1;
    check("ill.ex_bubble", 32'(ex_aluop_o[0]), 32'h0);
    check("ill.ex_rd",     32'(ex_rd_o[0]),    32'h0);
    check("ill.set",       32'(illegal_o[0]),  32'h1);
    tick();
    tick();
    #1;
    check("ill.sticky", 32'(illegal_o[0]), 32'h1);

    // Reset while an LDUR sits in MEM.
    put(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    tick();
    put(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    #1;
    check("mrst.mem_memread_pre", 32'(mem_memread_o[0]), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mrst.mem_memread",  32'(mem_memread_o[0]),  32'h0);
    check("mrst.mem_memwrite", 32'(mem_memwrite_o[0]), 32'h0);
    check("mrst.wb_regwrite",  32'(wb_regwrite_o[0]),  32'h0);
    check("mrst.illegal_op",   32'(illegal_o[0]),      32'h0);
    check("mrst.stall",        32'(stall_o[0]),        32'h0);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
